// File: rtl/cellrv32_xirq_prio.sv
// External interrupt controller: per-channel trigger type/polarity, 2-bit priorities
// with threshold, and a CPU request held until software acknowledges the claim.
module cellrv32_xirq_prio #(
  parameter int          XIRQ_NUM_CH           = 8,
  parameter logic [31:0] XIRQ_TRIGGER_TYPE     = 32'h0,
  parameter logic [31:0] XIRQ_TRIGGER_POLARITY = 32'h0,
  parameter logic [31:0] BASE_ADDR             = 32'hFFFF_F300
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic        rden_i,
  input  logic        wren_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  input  logic [31:0] xirq_i,
  output logic        cpu_irq_o
);

  localparam logic [31:0] CH_MASK   = 32'hFFFF_FFFF >> (32 - XIRQ_NUM_CH);
  localparam logic [63:0] PRIO_MASK = 64'hFFFF_FFFF_FFFF_FFFF >> (64 - 2 * XIRQ_NUM_CH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [31:0] eie, pend, ttype, tpol, prio_lo, prio_hi;
  logic [1:0]  thresh;
  logic [31:0] s1, s2, s3;
  logic [4:0]  src;
  logic [1:0]  prio;
  logic        ack_q;

  logic        in_win, wr, rd;
  logic [2:0]  reg_sel;
  logic [31:0] trig, clr_mask, rdata;
  logic [63:0] prio_all;
  logic        found;
  logic [4:0]  win_src;
  logic [1:0]  win_prio;
  logic        unused_addr;

  assign in_win      = (addr_i[31:5] == BASE_ADDR[31:5]);
  assign wr          = wren_i & in_win;
  assign rd          = rden_i & in_win;
  assign reg_sel     = addr_i[4:2];
  assign unused_addr = ^addr_i[1:0];
  assign prio_all    = {prio_hi, prio_lo};

  // level: s2 matches polarity; edge: s2/s3 transition in the polarity's direction
  assign trig = CH_MASK & ((~ttype & ~(s2 ^ tpol)) |
                           (ttype & tpol & s2 & ~s3) |
                           (ttype & ~tpol & ~s2 & s3));

  // ascending scan with strict '>' keeps the lowest index among equal priorities
  always_comb begin
    found    = 1'b0;
    win_src  = '0;
    win_prio = '0;
    for (int i = 0; i < XIRQ_NUM_CH; i++) begin
      if (pend[i] && eie[i] && (prio_all[2*i +: 2] >= thresh) &&
          (!found || (prio_all[2*i +: 2] > win_prio))) begin
        found    = 1'b1;
        win_src  = 5'(i);
        win_prio = prio_all[2*i +: 2];
      end
    end
  end

  always_comb begin
    clr_mask = '0;
    if (wr && (reg_sel == 3'd1)) clr_mask = ~data_i & CH_MASK;
    if (ack_q) clr_mask[src] = 1'b1;
  end

  always_comb begin
    case (reg_sel)
      3'd0:    rdata = eie;
      3'd1:    rdata = pend;
      3'd2:    rdata = {(state == RUN), 21'b0, prio, 3'b0, src};
      3'd3:    rdata = ttype;
      3'd4:    rdata = tpol;
      3'd5:    rdata = prio_lo;
      3'd6:    rdata = prio_hi;
      default: rdata = {30'b0, thresh};
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      eie     <= '0;
      pend    <= '0;
      ttype   <= XIRQ_TRIGGER_TYPE & CH_MASK;
      tpol    <= XIRQ_TRIGGER_POLARITY & CH_MASK;
      prio_lo <= '0;
      prio_hi <= '0;
      thresh  <= '0;
      s1      <= '0;
      s2      <= '0;
      s3      <= '0;
      ack_o   <= 1'b0;
      data_o  <= '0;
    end else begin
      s1     <= xirq_i & CH_MASK;
      s2     <= s1;
      s3     <= s2;
      pend   <= (pend | (trig & eie)) & ~clr_mask;
      ack_o  <= rd | wr;
      data_o <= rd ? rdata : '0;
      if (wr) begin
        case (reg_sel)
          3'd0:    eie     <= data_i & CH_MASK;
          3'd3:    ttype   <= data_i & CH_MASK;
          3'd4:    tpol    <= data_i & CH_MASK;
          3'd5:    prio_lo <= data_i & PRIO_MASK[31:0];
          3'd6:    prio_hi <= data_i & PRIO_MASK[63:32];
          3'd7:    thresh  <= data_i[1:0];
          default: ;
        endcase
      end
    end
  end

  // acknowledge is registered first; repeated ESC writes during that cycle are ignored
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      src       <= '0;
      prio      <= '0;
      cpu_irq_o <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      ack_q <= wr && (reg_sel == 3'd2) && (state == RUN) && !ack_q;
      case (state)
        IDLE: begin
          src  <= win_src;
          prio <= win_prio;
          if (found) begin
            state     <= RUN;
            cpu_irq_o <= 1'b1;
          end
        end
        RUN: begin
          if (ack_q) begin
            state     <= IDLE;
            cpu_irq_o <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cellrv32_xirq_prio.sv
// Scoreboard bench for cellrv32_xirq_prio: bus responses are queued at issue and
// checked by a monitor; interrupt arbitration is predicted by a behavioural model.
module tb_cellrv32_xirq_prio;

  localparam int          NCH  = 8;
  localparam logic [31:0] TT   = 32'h1234_00C3;
  localparam logic [31:0] BASE = 32'hFFFF_F300;

  localparam logic [4:0] O_EIE = 5'h00, O_EIP = 5'h04, O_ESC = 5'h08, O_TT = 5'h0C,
                         O_TP = 5'h10, O_PLO = 5'h14, O_PHI = 5'h18, O_TH = 5'h1C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic        rden = 1'b0;
  logic        wren = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ack;
  logic [31:0] xirq = '0;
  logic        irq;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  // behavioural model state
  logic [31:0] m_pend;
  int          m_prio[NCH];
  int          m_thr;
  logic [31:0] m_eie;

  cellrv32_xirq_prio #(
    .XIRQ_NUM_CH(NCH),
    .XIRQ_TRIGGER_TYPE(TT),
    .XIRQ_TRIGGER_POLARITY(32'h0),
    .BASE_ADDR(BASE)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .addr_i(addr),
    .rden_i(rden),
    .wren_i(wren),
    .data_i(wdata),
    .data_o(rdata),
    .ack_o(ack),
    .xirq_i(xirq),
    .cpu_irq_o(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // monitor: every acknowledged transfer consumes one scoreboard entry
  always @(negedge clk) begin
    logic [31:0] e;
    string       n;
    if (ack) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack data=%h want=no_ack", rdata);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (rdata !== e) begin
          bad++;
          $display("FAIL %s got=%h want=%h", n, rdata, e);
        end
      end
    end else if (rdata !== 32'h0) begin
      total++;
      bad++;
      $display("FAIL idle_data got=%h want=00000000", rdata);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // bus tasks start and end on a falling edge
  task automatic wr_reg(input logic [4:0] off, input logic [31:0] d);
    addr  = BASE | {27'b0, off};
    wdata = d;
    wren  = 1'b1;
    exp_q.push_back(32'h0);
    name_q.push_back("write_ack_data");
    @(negedge clk);
    wren = 1'b0;
  endtask

  task automatic rd_reg(input logic [4:0] off, input logic [31:0] want, input string name);
    addr = BASE | {27'b0, off};
    rden = 1'b1;
    exp_q.push_back(want);
    name_q.push_back(name);
    @(negedge clk);
    rden = 1'b0;
  endtask

  task automatic wait_irq(input logic lvl, input string name);
    int n;
    n = 0;
    while (irq !== lvl && n < 12) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'b0, irq}, {31'b0, lvl});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // highest priority wins, lowest index on a tie; -1 when nothing qualifies
  function automatic int winner();
    int w;
    w = -1;
    for (int i = 0; i < NCH; i++)
      if (m_pend[i] && m_eie[i] && m_prio[i] >= m_thr && (w < 0 || m_prio[i] > m_prio[w]))
        w = i;
    return w;
  endfunction

  task automatic set_prio(input logic [15:0] plo);
    for (int i = 0; i < NCH; i++) m_prio[i] = int'(plo[2*i +: 2]);
    wr_reg(O_PLO, {16'h0, plo});
  endtask

  // channels are high-level, all enabled; serve every qualifying request in order
  task automatic run_prio(input logic [15:0] plo, input int thr, input logic [7:0] lines);
    int w;
    set_prio(plo);
    m_thr = thr;
    wr_reg(O_TH, 32'(thr));
    xirq   = {24'h0, lines};
    m_pend = {24'h0, lines};
    idle(4);
    w = winner();
    while (w >= 0) begin
      wait_irq(1'b1, "prio_irq");
      rd_reg(O_ESC, 32'h8000_0000 | 32'(m_prio[w] << 8) | 32'(w), "prio_esc");
      xirq[w] = 1'b0;
      idle(3);
      wr_reg(O_ESC, 32'h0);
      m_pend[w] = 1'b0;
      @(negedge clk);
      check("prio_ack_drop", {31'b0, irq}, 32'h0);
      idle(2);
      w = winner();
    end
    idle(3);
    check("prio_no_irq", {31'b0, irq}, 32'h0);
    rd_reg(O_EIP, m_pend, "prio_eip_left");
    xirq = '0;
    idle(3);
    wr_reg(O_EIP, 32'h0);
    m_pend = '0;
    rd_reg(O_EIP, 32'h0, "prio_eip_clr");
  endtask

  initial begin
    int          r;
    logic [31:0] d, msk;
    logic [4:0]  off;

    m_pend = '0;
    m_eie  = '0;
    m_thr  = 0;
    for (int i = 0; i < NCH; i++) m_prio[i] = 0;

    // reset
    idle(2);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_ack", {31'b0, ack}, 32'h0);
    check("rst_data", rdata, 32'h0);
    rst = 1'b0;
    rd_reg(O_TT, TT & 32'hFF, "rst_ttype");
    rd_reg(O_ESC, 32'h0, "rst_esc");
    rd_reg(O_EIE, 32'h0, "rst_eie");
    rd_reg(O_EIP, 32'h0, "rst_eip");
    rd_reg(O_TP, 32'h0, "rst_tpol");

    // random register write/readback with channel masking
    for (int k = 0; k < 16; k++) begin
      r = $urandom_range(0, 5);
      d = $urandom;
      case (r)
        0:       begin off = O_EIE; msk = 32'hFF;   end
        1:       begin off = O_TT;  msk = 32'hFF;   end
        2:       begin off = O_TP;  msk = 32'hFF;   end
        3:       begin off = O_PLO; msk = 32'hFFFF; end
        4:       begin off = O_PHI; msk = 32'h0;    end
        default: begin off = O_TH;  msk = 32'h3;    end
      endcase
      wr_reg(off, d);
      rd_reg(off, d & msk, "reg_readback");
    end
    wr_reg(O_EIE, 32'h0);
    wr_reg(O_TT, 32'hFF);
    wr_reg(O_TP, 32'hFF);
    wr_reg(O_PLO, 32'h0);
    wr_reg(O_TH, 32'h0);
    idle(4);
    wr_reg(O_EIP, 32'h0);
    wr_reg(O_ESC, 32'h0);
    idle(4);
    check("clean_irq", {31'b0, irq}, 32'h0);
    rd_reg(O_EIP, 32'h0, "clean_eip");
    rd_reg(O_ESC, 32'h0, "clean_esc");

    // rising edge on channel 3, one-cycle pulse, exact latency
    wr_reg(O_TT, 32'h08);
    wr_reg(O_TP, 32'h08);
    wr_reg(O_EIE, 32'h08);
    xirq[3] = 1'b1;
    @(negedge clk);
    xirq[3] = 1'b0;
    idle(2);
    check("edge_early", {31'b0, irq}, 32'h0);
    @(negedge clk);
    check("edge_latency", {31'b0, irq}, 32'h1);
    rd_reg(O_ESC, 32'h8000_0003, "edge_esc");
    rd_reg(O_EIP, 32'h08, "edge_eip");
    wr_reg(O_ESC, 32'h0);
    @(negedge clk);
    check("edge_ack_drop", {31'b0, irq}, 32'h0);
    rd_reg(O_EIP, 32'h0, "edge_eip_clr");

    // priority arbitration, directed then random
    wr_reg(O_EIE, 32'h0);
    wr_reg(O_TT, 32'h0);
    wr_reg(O_TP, 32'hFF);
    idle(3);
    wr_reg(O_EIP, 32'h0);
    wr_reg(O_EIE, 32'hFF);
    m_eie = 32'hFF;
    run_prio(16'h3C04, 0, 8'h62);
    for (int k = 0; k < 8; k++)
      run_prio(16'($urandom), int'($urandom_range(0, 3)), 8'($urandom));

    // threshold: ch0 prio 1 blocked at 2, released at 1
    set_prio(16'h0001);
    wr_reg(O_TH, 32'h2);
    xirq[0] = 1'b1;
    idle(6);
    check("thresh_block", {31'b0, irq}, 32'h0);
    wr_reg(O_TH, 32'h1);
    @(negedge clk);
    check("thresh_release", {31'b0, irq}, 32'h1);
    rd_reg(O_ESC, 32'h8000_0100, "thresh_esc");
    xirq[0] = 1'b0;
    idle(3);
    wr_reg(O_ESC, 32'h0);
    idle(2);
    wr_reg(O_TH, 32'h0);
    wr_reg(O_EIE, 32'h0);

    // clear wins over a simultaneous edge set on channel 2
    wr_reg(O_TT, 32'h04);
    wr_reg(O_EIE, 32'h04);
    idle(3);
    wr_reg(O_EIP, 32'h0);
    xirq[2] = 1'b1;
    @(negedge clk);
    xirq[2] = 1'b0;
    @(negedge clk);
    wr_reg(O_EIP, 32'hFFFF_FFFB);
    idle(4);
    check("clrset_irq", {31'b0, irq}, 32'h0);
    rd_reg(O_EIP, 32'h0, "clrset_eip");
    rd_reg(O_TH, 32'h0, "thresh_read");
    rd_reg(O_PHI, 32'h0, "prio_hi_unused");

    // outside the window: no acknowledge
    addr = BASE + 32'h20;
    rden = 1'b1;
    @(negedge clk);
    rden = 1'b0;
    check("oow_ack_hi", {31'b0, ack}, 32'h0);
    addr = BASE - 32'h4;
    wren = 1'b1;
    wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    wren = 1'b0;
    check("oow_ack_lo", {31'b0, ack}, 32'h0);

    // level-low re-fire on channel 4
    wr_reg(O_PLO, 32'h0);
    wr_reg(O_TT, 32'h0);
    wr_reg(O_TP, 32'hEF);
    xirq = '0;
    wr_reg(O_EIE, 32'h10);
    wait_irq(1'b1, "refire_first");
    rd_reg(O_ESC, 32'h8000_0004, "refire_esc1");
    wr_reg(O_ESC, 32'h0);
    @(negedge clk);
    check("refire_drop", {31'b0, irq}, 32'h0);
    wait_irq(1'b1, "refire_again");
    rd_reg(O_ESC, 32'h8000_0004, "refire_esc2");

    // reset while claimed
    rst = 1'b1;
    @(negedge clk);
    check("rst_run_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;
    rd_reg(O_EIE, 32'h0, "rst_run_eie");
    rd_reg(O_TT, TT & 32'hFF, "rst_run_ttype");
    idle(3);

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
